// File: rtl/pipe_scroller.sv
// Pipe-stream consumer: scrolling wall buffer, bird collision and score.
// Columns enter at the right edge and discard at column 0.
module pipe_scroller #(
  parameter int ROWS     = 8,
  parameter int NCOLS    = 16,
  parameter int BIRD_COL = 3,
  parameter int SCORE_W  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      pattern_valid,
  input  logic [ROWS-1:0]           pattern,
  input  logic [$clog2(ROWS)-1:0]   bird_row,
  output logic [NCOLS*ROWS-1:0]     col_data,
  output logic                      hit,
  output logic [SCORE_W-1:0]        score,
  output logic                      score_tick
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DEAD
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [NCOLS*ROWS-1:0]   r_buf;
  logic                    r_hit;
  logic [SCORE_W-1:0]      r_score;
  logic                    r_tick;
  logic [ROWS-1:0]         w_bird_col;
  logic                    w_coll;
  logic                    w_shift;
  logic                    w_pass;

  assign w_bird_col = r_buf[BIRD_COL*ROWS +: ROWS];
  assign w_coll     = (r_state == S_RUN) && w_bird_col[bird_row];
  // A crash freezes the buffer even if a strobe arrives alongside it
  assign w_shift    = (r_state == S_RUN) && pattern_valid && !w_coll;
  assign w_pass     = w_shift && (|w_bird_col) && !(&r_score);

  always_comb begin
    w_next = r_state;
    if (!start) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  w_next = S_RUN;
        S_RUN:   w_next = w_coll ? S_DEAD : S_RUN;
        S_DEAD:  w_next = S_DEAD;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_buf   <= '0;
      r_hit   <= 1'b0;
      r_score <= '0;
      r_tick  <= 1'b0;
    end else if (!start) begin
      r_buf   <= '0;
      r_hit   <= 1'b0;
      r_score <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_tick <= w_pass;
      if (w_coll) r_hit <= 1'b1;
      if (w_shift) r_buf <= {pattern, r_buf[NCOLS*ROWS-1:ROWS]};
      if (w_pass) r_score <= r_score + 1'b1;
    end
  end

  assign col_data   = r_buf;
  assign hit        = r_hit;
  assign score      = r_score;
  assign score_tick = r_tick;

endmodule

// File: tb/tb_pipe_scroller.sv
// Bench for pipe_scroller: column-array game model checked every cycle,
// plus directed literal checks for each scenario.
module tb_pipe_scroller;

  logic         clk;
  logic         reset;
  logic         start;
  logic         pattern_valid;
  logic [7:0]   pattern;
  logic [2:0]   bird_row;
  logic [127:0] col_data;
  logic         hit;
  logic [7:0]   score;
  logic         score_tick;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 0;

  pipe_scroller dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .pattern_valid (pattern_valid),
    .pattern       (pattern),
    .bird_row      (bird_row),
    .col_data      (col_data),
    .hit           (hit),
    .score         (score),
    .score_tick    (score_tick)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Game model: columns as an array, phase 0=idle 1=playing 2=crashed
  logic [7:0] mcol [16];
  int         mscore;
  bit         mhit;
  bit         mtick;
  int         mphase;

  always @(posedge clk or negedge reset) begin
    if (!reset || !start) begin
      for (int i = 0; i < 16; i++) mcol[i] <= 8'h00;
      mscore <= 0;
      mhit   <= 0;
      mtick  <= 0;
      mphase <= 0;
    end else begin
      mtick <= 0;
      if (mphase == 0) begin
        mphase <= 1;
      end else if (mphase == 1) begin
        if (mcol[3][bird_row]) begin
          mhit   <= 1;
          mphase <= 2;
        end else if (pattern_valid) begin
          for (int i = 0; i < 15; i++) mcol[i] <= mcol[i+1];
          mcol[15] <= pattern;
          if (mcol[3] != 0 && mscore < 255) begin
            mscore <= mscore + 1;
            mtick  <= 1;
          end
        end
      end
    end
  end

  function automatic logic [127:0] mpack();
    logic [127:0] r;
    for (int c = 0; c < 16; c++) r[c*8 +: 8] = mcol[c];
    return r;
  endfunction

  function automatic logic [7:0] colof(int c);
    return col_data[c*8 +: 8];
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model col_data", col_data, mpack());
      chk("model hit", 128'(hit), 128'(mhit));
      chk("model score", 128'(score), 128'(mscore));
      chk("model score_tick", 128'(score_tick), 128'(mtick));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] p);
    pattern_valid = 1;
    pattern = p;
    step();
    pattern_valid = 0;
    pattern = 8'h00;
  endtask

  task automatic restart(input logic [2:0] br);
    start = 0;
    step();
    start = 1;
    bird_row = br;
    step();
  endtask

  initial begin
    reset = 0;
    start = 0;
    pattern_valid = 0;
    pattern = 0;
    bird_row = 3'd7;
    repeat (2) step();
    chk("reset col_data", col_data, 128'h0);
    chk("reset score", 128'(score), 128'h0);
    reset = 1;
    cmp_en = 1;
    step();
    start = 1;
    step();

    // fill buffer with 01..10, then push FF
    for (int k = 1; k <= 16; k++) strobe(8'(k));
    chk("fill col15", 128'(colof(15)), 128'h10);
    chk("fill col0", 128'(colof(0)), 128'h01);
    strobe(8'hFF);
    chk("shift col0", 128'(colof(0)), 128'h02);
    chk("shift col15", 128'(colof(15)), 128'hFF);
    chk("fill score", 128'(score), 128'd4);
    strobe(8'h00);
    chk("pre-reset score", 128'(score), 128'd5);

    // asynchronous reset mid-run
    reset = 0;
    #1;
    chk("async col_data", col_data, 128'h0);
    chk("async score", 128'(score), 128'h0);
    chk("async hit", 128'(hit), 128'h0);
    step();
    reset = 1;
    step();
    chk("post-reset col_data", col_data, 128'h0);

    // wall with gap at row 3: bird passes
    restart(3'd3);
    strobe(8'hE7);
    repeat (12) strobe(8'h00);
    chk("gap col3", 128'(colof(3)), 128'hE7);
    strobe(8'h00);
    chk("gap score", 128'(score), 128'd1);
    chk("gap tick", 128'(score_tick), 128'd1);
    step();
    chk("gap tick drop", 128'(score_tick), 128'd0);
    chk("gap hit", 128'(hit), 128'd0);

    // same wall at row 7: crash, then frozen
    restart(3'd7);
    strobe(8'hE7);
    repeat (12) strobe(8'h00);
    chk("crash pre hit", 128'(hit), 128'd0);
    step();
    chk("crash hit", 128'(hit), 128'd1);
    repeat (3) strobe(8'h3C);
    chk("frozen col3", 128'(colof(3)), 128'hE7);
    chk("frozen col15", 128'(colof(15)), 128'h00);
    chk("frozen score", 128'(score), 128'd0);

    // strobe lands in the collision cycle
    restart(3'd7);
    strobe(8'hE7);
    repeat (12) strobe(8'h00);
    strobe(8'h55);
    chk("coincide hit", 128'(hit), 128'd1);
    chk("coincide col15", 128'(colof(15)), 128'h00);
    chk("coincide col3", 128'(colof(3)), 128'hE7);
    chk("coincide score", 128'(score), 128'd0);

    // saturate score, then clear via start=0
    restart(3'd7);
    repeat (300) strobe(8'h01);
    chk("sat score", 128'(score), 128'd255);
    chk("sat tick", 128'(score_tick), 128'd0);
    start = 0;
    step();
    chk("clear score", 128'(score), 128'd0);
    chk("clear col_data", col_data, 128'h0);
    chk("clear hit", 128'(hit), 128'd0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
